ram_arbiter: RTL and testbench
==============================

// Module: ram_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and access sequencer for the 32x8 RAM1 block.
//  Serialises read/write transactions from two masters onto RAM1's single port:
//  clk, wena, addr[4:0], datain[7:0], dataout[7:0].
//  Masters use a req/ack handshake.
//  Sits between datapath clients (e.g. a CPU fetch unit and a loader) and RAM1.
// PARAMETERS
//  AW        5  RAM address width (RAM1 depth = 2**AW)
//  DW        8  RAM data width
//  READ_LAT  1  cycles from address driven to RAM1 dataout valid (1..3)
// PORTS
//  clk        in   1   system clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  req0       in   1   master 0 request, held until ack0
//  we0        in   1   master 0 write(1)/read(0), stable while req0
//  addr0      in   AW  master 0 address, stable while req0
//  wdata0     in   DW  master 0 write data, stable while req0
//  ack0       out  1   one-cycle completion pulse to master 0
//  rdata0     out  DW  read data, valid in ack0 cycle for reads
//  req1/we1/addr1/wdata1/ack1/rdata1   same as master 0, for master 1
//  ram_wena   out  1   to RAM1 wena (1 = write)
//  ram_addr   out  AW  to RAM1 addr
//  ram_din    out  DW  to RAM1 datain
//  ram_dout   in   DW  from RAM1 dataout
//  busy       out  1   high whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; ram_wena/ram_addr/ram_din=0; ack*=0; rdata*=0; busy=0.
//   - RR pointer set so master 0 wins the first tie.
//  States and transitions:
//   - IDLE: on an edge with any req, latch winner id, we, addr, wdata -> ACCESS.
//   - ACCESS: drive ram_* from the latch; ram_wena=we for exactly this one cycle.
//     Write -> DONE. Read -> WAIT.
//   - WAIT: hold ram_addr, ram_wena=0; count READ_LAT cycles.
//     On the last count, capture ram_dout into the winner's rdata -> DONE.
//   - DONE: ack[winner]=1 for this single cycle; update RR pointer to the other master -> IDLE.
//  Latency, req sampled at edge k:
//   - write: ack high in cycle k+2.
//   - read: ack high in cycle k+2+READ_LAT.
//  Arbitration:
//   - Single req: granted.
//   - Both req: grant != last-granted.
//   - The forced IDLE cycle after DONE lets a master that keeps req high start back-to-back
//     transfers, but it loses to a pending other master.
//  Handshake rules:
//   - Inputs are latched at grant; changes after grant are ignored.
//   - A req dropped before ack still completes; ack is issued anyway.
//   - rdata* holds its last captured value until that master's next read.
//   - Writes never modify rdata*.
//  Read-after-write to the same address by either master returns the new data.
//  Outside ACCESS, ram_wena=0, so RAM1 is never written spuriously.
//  Reset mid-transaction aborts it:
//   - No ack is issued.
//   - A write aborted before its ACCESS edge does not occur.
// CONFIGURATION
//  RAM_ARB_STATS_EN defined:
//   - Adds outputs gnt_cnt0 and gnt_cnt1 [15:0].
//   - Each increments in DONE for its master; reset 0; wraps at 16'hFFFF -> 0.
//  RAM_ARB_STATS_EN undefined: these ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package ram_arb_pkg:
//   - state_t enum {IDLE, ACCESS, WAIT, DONE}
//   - AW/DW defaults
//   - localparam READ_LAT_MAX=3
//  Sub-module rr_arb2: combinational 2-way round-robin pick.
//   - Inputs: req[1:0], last.
//   - Outputs: gnt[1:0], id.
//  FSM, latches and RAM drive stay in ram_arbiter.
// TESTING
//  Drive RAM1 instance, clk period 10 ns, READ_LAT=1.
//  1. m0 write addr 5'h01 data 8'h24; later m0 read 5'h01
//     -> ack0 at k+2 for the write; rdata0=8'h24 at ack0 for the read.
//  2. m0 write 5'h03=8'h2C and m1 write 5'h03=8'h55, requested on the same edge after reset
//     -> m0 acked first, then m1; a subsequent read returns 8'h55.
//  3. Both masters hold req continuously for 6 transactions
//     -> grants alternate 0,1,0,1,0,1; ram_wena never high outside ACCESS.
//  4. m1 read 5'h1F after writing 8'hFF there, while m0 is idle
//     -> ack1 at k+3; rdata1=8'hFF; rdata0 unchanged.
//  5. rst_n low during the ACCESS of an m0 write to 5'h07 (old 8'h00)
//     -> no ack0; all outputs 0 asynchronously; a later read of 5'h07 returns 8'h00.
//  6. RAM_ARB_STATS_EN set: 3 m0 and 2 m1 transactions -> gnt_cnt0=3, gnt_cnt1=2; reset clears both to 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state type and default geometry for the RAM1 arbiter
package ram_arb_pkg;
   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;
   localparam int RAM_AW = 5;
   localparam int RAM_DW = 8;
   localparam int READ_LAT_MAX = 3;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: two-master req/ack bus plus the RAM1 single-port connection
interface ram_arbiter_if import ram_arb_pkg::*; #(
   parameter int AW = RAM_AW,
   parameter int DW = RAM_DW
);
   logic req0, we0, ack0, req1, we1, ack1, ram_wena, busy;
   logic [AW-1:0] addr0, addr1, ram_addr;
   logic [DW-1:0] wdata0, rdata0, wdata1, rdata1, ram_din, ram_dout;
   modport slave (
      input req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
      output ack0, rdata0, ack1, rdata1, ram_wena, ram_addr, ram_din, busy
   );
   modport master (
      output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, ram_dout,
      input ack0, rdata0, ack1, rdata1, ram_wena, ram_addr, ram_din, busy
   );
endinterface

// File: rtl/ram_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick; on a tie the master other than last wins
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt,
   output logic       id
);
   assign id = req[1] & (~req[0] | ~last);
   assign gnt = {req[1] & id, req[0] & ~id};
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin sequencer serialising two req/ack masters onto RAM1.
// Optional grant counters gnt_cnt0/gnt_cnt1 when RAM_ARB_STATS_EN is defined.
module ram_arbiter import ram_arb_pkg::*; #(
   parameter int AW = RAM_AW,
   parameter int DW = RAM_DW,
   parameter int READ_LAT = 1
) (
   input logic clk,
   input logic rst_n,
   ram_arbiter_if.slave bus
`ifdef RAM_ARB_STATS_EN
   ,
   output logic [15:0] gnt_cnt0,
   output logic [15:0] gnt_cnt1
`endif
);
   localparam int CW = $clog2(READ_LAT_MAX);
   if (READ_LAT < 1 || READ_LAT > READ_LAT_MAX) begin : g_lat_chk
      $error("ram_arbiter: READ_LAT out of range");
   end
   state_t state, state_n;
   logic [1:0] gnt;
   logic id, id_q, last, grant, last_rd, sel_we;
   logic [CW-1:0] cnt;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_din;
   rr_arb2 u_rr (.req({bus.req1, bus.req0}), .last(last), .gnt(gnt), .id(id));
   assign grant = state == IDLE && |gnt;
   assign last_rd = state == WAIT && cnt == CW'(READ_LAT - 1);
   assign sel_we = gnt[1] ? bus.we1 : bus.we0;
   assign sel_addr = gnt[1] ? bus.addr1 : bus.addr0;
   assign sel_din = gnt[1] ? bus.wdata1 : bus.wdata0;
   assign bus.busy = state != IDLE;
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    state_n = grant ? ACCESS : IDLE;
         ACCESS:  state_n = bus.ram_wena ? DONE : WAIT;
         WAIT:    state_n = last_rd ? DONE : WAIT;
         default: state_n = IDLE;
      endcase
   end
   // ram_addr/ram_din double as the transaction latch, so they hold through WAIT
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         id_q <= 1'b0;
         last <= 1'b1;
         cnt <= '0;
         bus.ram_wena <= 1'b0;
         bus.ram_addr <= '0;
         bus.ram_din <= '0;
         bus.ack0 <= 1'b0;
         bus.ack1 <= 1'b0;
         bus.rdata0 <= '0;
         bus.rdata1 <= '0;
      end else begin
         state <= state_n;
         cnt <= state == WAIT ? cnt + 1'b1 : '0;
         bus.ram_wena <= grant ? sel_we : 1'b0;
         if (grant) begin
            id_q <= id;
            bus.ram_addr <= sel_addr;
            bus.ram_din <= sel_din;
         end
         if (last_rd && !id_q) bus.rdata0 <= bus.ram_dout;
         if (last_rd && id_q) bus.rdata1 <= bus.ram_dout;
         bus.ack0 <= state_n == DONE && !id_q;
         bus.ack1 <= state_n == DONE && id_q;
         if (state == DONE) last <= id_q;
      end
`ifdef RAM_ARB_STATS_EN
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         gnt_cnt0 <= '0;
         gnt_cnt1 <= '0;
      end else if (state == DONE) begin
         if (id_q) gnt_cnt1 <= gnt_cnt1 + 1'b1;
         else gnt_cnt0 <= gnt_cnt0 + 1'b1;
      end
`endif
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vector bench for ram_arbiter driving a behavioural RAM1 model
module tb_ram_arbiter;
   import ram_arb_pkg::*;
   typedef struct {
      int m;
      logic we;
      logic [4:0] addr;
      logic [7:0] wdata;
      logic [7:0] r0;
      logic [7:0] r1;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int errors = 0;
   logic [7:0] mem [32] = '{default: 8'h00};
   ram_arbiter_if #(.AW(5), .DW(8)) bus ();
`ifdef RAM_ARB_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif
   ram_arbiter #(.AW(5), .DW(8), .READ_LAT(1)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
`ifdef RAM_ARB_STATS_EN
      ,
      .gnt_cnt0(gnt_cnt0),
      .gnt_cnt1(gnt_cnt1)
`endif
   );
   always #5 clk = ~clk;
   // RAM1: synchronous write, registered read (one cycle latency)
   always @(posedge clk) begin
      if (bus.ram_wena) mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= mem[bus.ram_addr];
   end
   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   always @(negedge clk)
      if (bus.ram_wena) chk("wena_outside_access", int'(dut.state == ACCESS), 1);
   task automatic drive(int m, logic req, logic we, logic [4:0] a, logic [7:0] d);
      if (m == 0) begin
         bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
      end else begin
         bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
      end
   endtask
   task automatic wait_ack(output int who, output int n);
      who = -1;
      for (n = 1; n <= 12; n++) begin
         @(negedge clk);
         if (bus.ack0 || bus.ack1) begin
            who = (bus.ack0 && bus.ack1) ? 2 : bus.ack1 ? 1 : 0;
            break;
         end
      end
      if (who < 0) chk("ack_timeout", 0, 1);
   endtask
   task automatic xact(int m, logic we, logic [4:0] a, logic [7:0] d);
      int who, n;
      drive(m, 1'b1, we, a, d);
      @(posedge clk);
      wait_ack(who, n);
      drive(m, 1'b0, we, a, d);
      chk("ack_master", who, m);
      chk("ack_latency", n, we ? 2 : 3);
      @(posedge clk);
      #1;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      drive(0, 1'b0, 1'b0, 5'h00, 8'h00);
      drive(1, 1'b0, 1'b0, 5'h00, 8'h00);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
   initial begin
      vec_t v[9];
      int who, n;
      v = '{
         '{0, 1'b1, 5'h01, 8'h24, 8'h00, 8'h00},
         '{0, 1'b0, 5'h01, 8'h00, 8'h24, 8'h00},
         '{1, 1'b1, 5'h1F, 8'hFF, 8'h24, 8'h00},
         '{1, 1'b0, 5'h1F, 8'h00, 8'h24, 8'hFF},
         '{0, 1'b1, 5'h1F, 8'h11, 8'h24, 8'hFF},
         '{1, 1'b0, 5'h01, 8'h00, 8'h24, 8'h24},
         '{0, 1'b0, 5'h1F, 8'h00, 8'h11, 8'h24},
         '{0, 1'b1, 5'h00, 8'hA5, 8'h11, 8'h24},
         '{1, 1'b0, 5'h00, 8'h00, 8'h11, 8'hA5}
      };
      do_reset();
      chk("rst_ack0", bus.ack0, 0);
      chk("rst_ack1", bus.ack1, 0);
      chk("rst_rdata0", bus.rdata0, 0);
      chk("rst_rdata1", bus.rdata1, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_wena", bus.ram_wena, 0);
      chk("rst_addr", bus.ram_addr, 0);
      chk("rst_din", bus.ram_din, 0);
      foreach (v[i]) begin
         xact(v[i].m, v[i].we, v[i].addr, v[i].wdata);
         chk("vec_rdata0", bus.rdata0, v[i].r0);
         chk("vec_rdata1", bus.rdata1, v[i].r1);
         chk("vec_busy_idle", bus.busy, 0);
      end
      // simultaneous requests right after reset: m0 wins the first tie
      do_reset();
      drive(0, 1'b1, 1'b1, 5'h03, 8'h2C);
      drive(1, 1'b1, 1'b1, 5'h03, 8'h55);
      @(posedge clk);
      wait_ack(who, n);
      chk("tie_first", who, 0);
      chk("tie_first_lat", n, 2);
      chk("tie_busy", bus.busy, 1);
      drive(0, 1'b0, 1'b1, 5'h03, 8'h2C);
      wait_ack(who, n);
      chk("tie_second", who, 1);
      chk("tie_second_lat", n, 3);
      drive(1, 1'b0, 1'b1, 5'h03, 8'h55);
      @(posedge clk);
      #1;
      xact(0, 1'b0, 5'h03, 8'h00);
      chk("tie_readback", bus.rdata0, 8'h55);
      // both masters hold req: grants must alternate
      do_reset();
      drive(0, 1'b1, 1'b1, 5'h10, 8'h10);
      drive(1, 1'b1, 1'b1, 5'h11, 8'h11);
      @(posedge clk);
      for (int i = 0; i < 6; i++) begin
         wait_ack(who, n);
         chk("alt_grant", who, i % 2);
      end
      drive(0, 1'b0, 1'b1, 5'h10, 8'h10);
      drive(1, 1'b0, 1'b1, 5'h11, 8'h11);
      @(posedge clk);
      #1;
      chk("alt_busy_idle", bus.busy, 0);
      xact(1, 1'b0, 5'h10, 8'h00);
      chk("alt_readback", bus.rdata1, 8'h10);
      // reset during the ACCESS cycle of a write aborts it
      drive(0, 1'b1, 1'b1, 5'h07, 8'h5A);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_wena", bus.ram_wena, 0);
      chk("abort_addr", bus.ram_addr, 0);
      chk("abort_din", bus.ram_din, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_ack0", bus.ack0, 0);
      chk("abort_rdata1", bus.rdata1, 0);
      drive(0, 1'b0, 1'b1, 5'h07, 8'h5A);
      @(posedge clk);
      #3 rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("abort_no_ack0", bus.ack0, 0);
      end
      @(posedge clk);
      #1;
      chk("abort_mem", mem[7], 8'h00);
      xact(0, 1'b0, 5'h07, 8'h00);
      chk("abort_readback", bus.rdata0, 8'h00);
`ifdef RAM_ARB_STATS_EN
      do_reset();
      xact(0, 1'b1, 5'h02, 8'h01);
      xact(1, 1'b1, 5'h04, 8'h02);
      xact(0, 1'b0, 5'h02, 8'h00);
      xact(1, 1'b0, 5'h04, 8'h00);
      xact(0, 1'b1, 5'h05, 8'h03);
      chk("stats_cnt0", gnt_cnt0, 3);
      chk("stats_cnt1", gnt_cnt1, 2);
      rst_n = 1'b0;
      #1;
      chk("stats_rst_cnt0", gnt_cnt0, 0);
      chk("stats_rst_cnt1", gnt_cnt1, 0);
      do_reset();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
